bin_to_bcd_seq: RTL and testbench

- Sequential double-dabble converter that sits between odd_one_out and the four-digit seven-segment driver.
- Accepts the binary result when a start strobe arrives and produces DIGITS packed BCD digits, one shift per clock.
- Also produces a leading-zero blanking mask so the display shows "9" rather than "009".
- Result registers hold their value between conversions, so the display never flickers during a conversion.

---
 rtl/odd_one_out_pkg.sv | 29 ++
 rtl/bcd_add3_digit.sv | 15 +
 rtl/bin_to_bcd_seq.sv | 126 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/odd_one_out_pkg.sv
// Shared types and constants for the result-display path (converter and display driver).
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: FSM state enum, BCD digit geometry, double-dabble threshold,
// default display sizing and a compile-time power-of-ten helper.
package odd_one_out_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int BCD_DIGIT_W    = 4;
  localparam int ADD3_THRESH    = 5;
  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_DIGITS = 3;

  // 10^n, used only at elaboration to check that DIGITS can hold 2^WIDTH-1.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
// Latency: combinational.
// Backpressure: none.
//
// Ports: din_i - current 4-bit scratch digit; dout_o - corrected digit, ready to be shifted.
module bcd_add3_digit
  import odd_one_out_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din_i,
  output logic [BCD_DIGIT_W-1:0] dout_o
);

  assign dout_o = (din_i >= BCD_DIGIT_W'(ADD3_THRESH)) ? din_i + BCD_DIGIT_W'(3) : din_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with leading-zero blanking mask.
// Latency: start accepted at edge k -> bcd/blank/done update at edge k+WIDTH.
// Backpressure: start is ignored (not queued) while busy; results hold until the next completion.
//
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   start, bin    - conversion request and binary operand (captured only when idle)
//   busy          - high exactly while shifting
//   done          - one-cycle pulse when bcd/blank take a new value
//   bcd           - packed BCD, digit 0 (ones) in bits [3:0]
//   blank         - bit i set when digit i is a leading zero; bit 0 always clear
module bin_to_bcd_seq
  import odd_one_out_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]             blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = BCD_DIGIT_W * DIGITS;

  // The largest input must fit in DIGITS decimal digits, otherwise a digit
  // would overflow during the add-3 correction.
  if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  // Leading-zero mask: scanning from the most significant digit, a digit is
  // blank while it and everything above it is zero. The ones digit always shows.
  function automatic logic [DIGITS-1:0] blank_of(input logic [BW-1:0] v);
    logic [DIGITS-1:0] b;
    logic              zero_run;
    b        = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      b[i]     = zero_run;
    end
    return b;
  endfunction

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              done_q, done_d;
  logic [BW-1:0]     corr;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .din_i  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout_o (corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Corrected scratch and the operand shift as one register; the
        // operand MSB enters scratch bit 0.
        {scratch_d, shreg_d} = {corr, shreg_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = scratch_d;
          blank_d = blank_of(scratch_d);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      blank_q   <= blank_of('0);
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      done_q    <= done_d;
    end
  end

  assign busy  = (state_q == SHIFT);
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [WIDTH-1:0]  bin;
  logic              busy;
  logic              done;
  logic [BW-1:0]     bcd;
  logic [DIGITS-1:0] blank;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .blank (blank)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Decimal digits of v, ones digit lowest.
  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Digit i (i>0) is a leading zero exactly when v < 10^i.
  function automatic logic [DIGITS-1:0] blank_rule(input int v);
    logic [DIGITS-1:0] b;
    int p;
    b = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      b[i] = (i > 0) && (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  // Transaction-level model: remaining shift cycles and the captured operand.
  int                m_rem = 0;
  int                m_val = 0;
  logic [BW-1:0]     m_bcd;
  logic [DIGITS-1:0] m_blank;
  logic              m_done;

  always @(posedge clk) begin
    if (reset) begin
      m_rem   = 0;
      m_bcd   = '0;
      m_blank = blank_rule(0);
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_bcd   = to_bcd(m_val);
          m_blank = blank_rule(m_val);
          m_done  = 1'b1;
        end
      end else if (start) begin
        m_val = int'(bin);
        m_rem = WIDTH;
      end
    end
  end

  logic chk_en   = 1'b0;
  int   busy_run = 0;
  int   done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_rem > 0);
      check("done", done, m_done);
      check("bcd", bcd, m_bcd);
      check("blank", blank, m_blank);
      check("busy_done_excl", busy & done, 1'b0);
      if (done) begin
        done_cnt++;
        check("busy_len", busy_run, WIDTH);
        busy_run = 0;
      end else if (busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done with a bound; bin is scrambled meanwhile to show it is not re-read.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      bin = WIDTH'($urandom);
      tick();
      n++;
    end
    if (!done) check("done_timeout", done, 1'b1);
  endtask

  task automatic run_conv(input logic [WIDTH-1:0] v, output int n);
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    wait_done(n);
  endtask

  initial begin
    int n;
    int d0;
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    tick();
    tick();
    chk_en = 1'b1;

    check("pin_bcd_255", to_bcd(255), 12'h255);
    check("pin_bcd_9", to_bcd(9), 12'h009);
    check("pin_blank_0", blank_rule(0), 3'b110);
    check("pin_blank_42", blank_rule(42), 3'b100);
    check("pin_blank_100", blank_rule(100), 3'b000);

    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bcd", bcd, 12'h000);
    check("rst_blank", blank, 3'b110);

    reset = 1'b0;
    tick();

    run_conv(0, n);
    check("lat_0", n, 8);
    check("bcd_0", bcd, 12'h000);
    check("blank_0", blank, 3'b110);
    run_conv(255, n);
    check("bcd_255", bcd, 12'h255);
    check("blank_255", blank, 3'b000);
    run_conv(9, n);
    check("bcd_9", bcd, 12'h009);
    check("blank_9", blank, 3'b110);
    run_conv(100, n);
    check("bcd_100", bcd, 12'h100);
    check("blank_100", blank, 3'b000);

    // Stray start in the middle of a conversion.
    tick();
    d0    = done_cnt;
    start = 1'b1;
    bin   = 42;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    bin   = 200;
    tick();
    start = 1'b0;
    wait_done(n);
    check("stray_lat", n, 5);
    check("stray_bcd", bcd, 12'h042);
    repeat (12) tick();
    check("stray_done_cnt", done_cnt - d0, 1);

    // Back-to-back: start held on the done cycle.
    run_conv(17, n);
    check("b2b_bcd_17", bcd, 12'h017);
    start = 1'b1;
    bin   = 58;
    tick();
    start = 1'b0;
    wait_done(n);
    check("b2b_gap", n + 1, 9);
    check("b2b_bcd_58", bcd, 12'h058);

    // Reset in the middle of a conversion.
    tick();
    start = 1'b1;
    bin   = 199;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d0    = done_cnt;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_bcd", bcd, 12'h000);
    check("mid_rst_blank", blank, 3'b110);
    repeat (10) tick();
    check("mid_rst_no_done", done_cnt - d0, 0);
    run_conv(199, n);
    check("after_rst_bcd", bcd, 12'h199);

    // Full sweep with random idle gaps.
    for (int v = 0; v < 256; v++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_conv(WIDTH'(v), n);
      check("sweep_bcd", bcd, to_bcd(v));
      check("sweep_blank", blank, blank_rule(v));
    end
    tick();
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
